sum_arbiter: RTL and testbench

- Time-shares one epoch accumulator adder across CHANNELS actigraphy sample streams.
- Keeps a per-channel sample count and running sum, and serves one input sample per cycle under round-robin arbitration.
- When a channel has collected SAMPLES samples, its epoch total is emitted with the channel index on a single valid/ready output.
- Sits between the per-sensor sample sources and the feature/classifier stage.

---
 rtl/sum_arbiter.sv | 119 +++++++++++
 tb/tb_sum_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_arbiter.sv
// Round-robin time-shared epoch accumulator: sums SAMPLES samples per channel and
// emits each channel's epoch total on one valid/ready output, lowest pending index first.
module sum_arbiter #(
    parameter int CHANNELS = 4,
    parameter int SAMPLES  = 15,
    parameter int DATA_W   = 8,
    parameter int CH_W     = $clog2(CHANNELS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNELS*DATA_W-1:0] i_data,
    input  logic [CHANNELS-1:0]        i_valid,
    output logic [CHANNELS-1:0]        i_ready,
    output logic [DATA_W-1:0]          o_data,
    output logic [CH_W-1:0]            o_channel,
    output logic                       o_valid,
    input  logic                       o_ready
);
    localparam int CNT_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLES - 1);

    logic [CNT_W-1:0]    count [CHANNELS];
    logic [DATA_W-1:0]   sum   [CHANNELS];
    logic [CHANNELS-1:0] pending;
    logic [CH_W-1:0]     rr_ptr;

    logic [CHANNELS-1:0] eligible;
    logic                grant_valid;
    logic [CH_W-1:0]     grant;
    logic [CH_W-1:0]     idx;
    logic                load;
    logic [CH_W-1:0]     drain;
    logic [CH_W-1:0]     rr_next;
    logic [DATA_W-1:0]   sample;

    assign eligible = i_valid & ~pending;

    // Scan downward so the candidate closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = CH_W'((int'(rr_ptr) + k) % CHANNELS);
            if (eligible[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

    always_comb begin
        i_ready = '0;
        if (grant_valid) begin
            i_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        drain = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (pending[c]) begin
                drain = CH_W'(c);
            end
        end
    end

    assign load    = (~o_valid | o_ready) & (|pending);
    assign sample  = i_data[int'(grant)*DATA_W +: DATA_W];
    assign rr_next = CH_W'((int'(grant) + 1) % CHANNELS);

    // A drained channel is always pending and a granted one never is, so the two branches are exclusive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                count[c] <= '0;
                sum[c]   <= '0;
            end
            pending <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (load && drain == CH_W'(c)) begin
                    pending[c] <= 1'b0;
                    sum[c]     <= '0;
                    count[c]   <= '0;
                end else if (grant_valid && grant == CH_W'(c)) begin
                    sum[c] <= sum[c] + sample;
                    if (count[c] == LAST) begin
                        pending[c] <= 1'b1;
                    end else begin
                        count[c] <= count[c] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= rr_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_channel <= '0;
        end else if (load) begin
            o_valid   <= 1'b1;
            o_data    <= sum[drain];
            o_channel <= drain;
        end else if (o_valid && o_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sum_arbiter.sv
// Bench for sum_arbiter: directed scenarios plus random traffic, all checked against
// a per-cycle behavioural model of the arbiter's accumulate / drain rules.
module tb_sum_arbiter;
    localparam int CH = 4;
    localparam int S  = 15;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [CH*DW-1:0]  i_data;
    logic [CH-1:0]     i_valid;
    logic [CH-1:0]     i_ready;
    logic [DW-1:0]     o_data;
    logic [1:0]        o_channel;
    logic              o_valid;
    logic              o_ready;

    always #5 clk = ~clk;

    sum_arbiter #(.CHANNELS(CH), .SAMPLES(S), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
        .o_data(o_data), .o_channel(o_channel), .o_valid(o_valid), .o_ready(o_ready)
    );

    logic [CH-1:0] src_valid;
    logic [DW-1:0] src_data [CH];
    logic          src_ordy;
    logic [CH-1:0] got_ready, exp_ready;

    // Model: samples collected so far, running total, waiting flag, pointer, output register.
    int m_cnt [CH];
    int m_sum [CH];
    bit m_pend [CH];
    int m_rr;
    bit m_ov;
    int m_od, m_och;

    int nvec = 0, nerr = 0;
    int acc [CH];
    int em_ch[$], em_data[$];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_cnt[c] = 0; m_sum[c] = 0; m_pend[c] = 0; acc[c] = 0;
        end
        m_rr = 0; m_ov = 0; m_od = 0; m_och = 0;
    endtask

    function automatic int model_grant();
        for (int k = 0; k < CH; k++) begin
            int c;
            c = (m_rr + k) % CH;
            if (src_valid[c] && !m_pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        src_valid = '0; src_ordy = 1'b0;
        for (int c = 0; c < CH; c++) src_data[c] = '0;
        i_valid = '0; o_ready = 1'b0; i_data = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        em_ch.delete(); em_data.delete();
        got_ready = '0; exp_ready = '0;
    endtask

    // One clock: drive at negedge, sample combinational/handshake, advance model at posedge.
    task automatic step();
        int g, p;
        @(negedge clk);
        i_valid = src_valid;
        for (int c = 0; c < CH; c++) i_data[c*DW +: DW] = src_data[c];
        o_ready = src_ordy;
        #1;
        got_ready = i_ready;
        g = model_grant();
        exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        if (o_valid && o_ready) begin
            em_ch.push_back(int'(o_channel));
            em_data.push_back(int'(o_data));
        end
        for (int c = 0; c < CH; c++) if (got_ready[c]) acc[c]++;
        @(posedge clk);
        p = -1;
        for (int c = CH - 1; c >= 0; c--) if (m_pend[c]) p = c;
        if (p >= 0 && (!m_ov || src_ordy)) begin
            m_ov = 1; m_od = m_sum[p]; m_och = p;
            m_pend[p] = 0; m_sum[p] = 0; m_cnt[p] = 0;
        end else if (m_ov && src_ordy) begin
            m_ov = 0;
        end
        if (g >= 0) begin
            m_sum[g] = (m_sum[g] + int'(src_data[g])) % 256;
            m_cnt[g]++;
            if (m_cnt[g] == S) m_pend[g] = 1;
            m_rr = (g + 1) % CH;
        end
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL reset o_valid got=%b exp=0", o_valid); end
        nvec++; if (o_data !== 8'd0) begin nerr++; $display("FAIL reset o_data got=%0d exp=0", o_data); end
        nvec++; if (o_channel !== 2'd0) begin nerr++; $display("FAIL reset o_channel got=%0d exp=0", o_channel); end
        nvec++; if (i_ready !== 4'b0000) begin nerr++; $display("FAIL reset i_ready got=%b exp=0000", i_ready); end
    endtask

    task automatic test_single_channel();
        apply_reset();
        src_ordy = 1'b1; src_valid = 4'b0001; src_data[0] = 8'd2;
        for (int i = 0; i < 40 && acc[0] < S; i++) begin
            step();
            nvec++; if (got_ready !== exp_ready) begin nerr++; $display("FAIL single i_ready got=%b exp=%b", got_ready, exp_ready); end
            nvec++; if (o_valid !== m_ov || o_data !== m_od || o_channel !== m_och) begin
                nerr++; $display("FAIL single out got v=%b d=%0d ch=%0d exp v=%b d=%0d ch=%0d", o_valid, o_data, o_channel, m_ov, m_od, m_och);
            end
        end
        nvec++; if (acc[0] != S) begin nerr++; $display("FAIL single accepts got=%0d exp=%0d", acc[0], S); end
        nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL single latency0 o_valid got=%b exp=0", o_valid); end
        src_valid = '0;
        step();
        nvec++; if (o_valid !== 1'b1 || o_data !== 8'd30 || o_channel !== 2'd0) begin
            nerr++; $display("FAIL single latency1 got v=%b d=%0d ch=%0d exp v=1 d=30 ch=0", o_valid, o_data, o_channel);
        end
        step();
        nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL single pulse o_valid got=%b exp=0", o_valid); end
        repeat (3) step();
        nvec++; if (em_ch.size() != 1 || em_data[0] != 30 || em_ch[0] != 0) begin
            nerr++; $display("FAIL single emitted count=%0d exp 1 total (ch0=30)", em_ch.size());
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        src_ordy = 1'b1; src_valid = 4'b1111;
        for (int c = 0; c < CH; c++) src_data[c] = DW'(c + 1);
        for (int i = 0; i < 4 * S; i++) begin
            step();
            nvec++; if (got_ready !== (4'b0001 << (i % CH))) begin
                nerr++; $display("FAIL rr grant cycle %0d got=%b exp=%b", i, got_ready, 4'b0001 << (i % CH));
            end
            nvec++; if (o_valid !== m_ov || o_data !== m_od || o_channel !== m_och) begin
                nerr++; $display("FAIL rr out got v=%b d=%0d ch=%0d exp v=%b d=%0d ch=%0d", o_valid, o_data, o_channel, m_ov, m_od, m_och);
            end
        end
        src_valid = '0;
        repeat (4) step();
        nvec++; if (em_ch.size() != CH) begin nerr++; $display("FAIL rr emit count got=%0d exp=%0d", em_ch.size(), CH); end
        for (int k = 0; k < CH && k < em_ch.size(); k++) begin
            nvec++; if (em_ch[k] != k || em_data[k] != S * (k + 1)) begin
                nerr++; $display("FAIL rr total %0d got ch=%0d d=%0d exp ch=%0d d=%0d", k, em_ch[k], em_data[k], k, S * (k + 1));
            end
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        src_ordy = 1'b1; src_valid = 4'b0010; src_data[1] = 8'd20;
        for (int i = 0; i < 40 && acc[1] < S; i++) step();
        src_valid = '0;
        repeat (4) step();
        nvec++; if (em_ch.size() != 1 || em_ch[0] != 1 || em_data[0] != 44) begin
            nerr++; $display("FAIL overflow got %0d totals first d=%0d exp one total ch1=44", em_ch.size(), (em_data.size() > 0) ? em_data[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        src_ordy = 1'b0;
        for (int c = 0; c < CH; c++) src_data[c] = DW'(c + 1);
        for (int i = 0; i < 120 && (acc[0] + acc[1] + acc[2] + acc[3]) < CH * S; i++) begin
            src_valid = {3'b111, acc[0] < S};
            step();
            nvec++; if (got_ready !== exp_ready) begin nerr++; $display("FAIL bp i_ready got=%b exp=%b", got_ready, exp_ready); end
            nvec++; if (o_valid !== m_ov || o_data !== m_od || o_channel !== m_och) begin
                nerr++; $display("FAIL bp out got v=%b d=%0d ch=%0d exp v=%b d=%0d ch=%0d", o_valid, o_data, o_channel, m_ov, m_od, m_och);
            end
        end
        nvec++; if (acc[0] + acc[1] + acc[2] + acc[3] != CH * S) begin nerr++; $display("FAIL bp timeout accepts got=%0d", acc[0] + acc[1] + acc[2] + acc[3]); end
        src_valid = 4'b1110;
        repeat (4) begin
            step();
            nvec++; if (got_ready !== 4'b0000) begin nerr++; $display("FAIL bp stall i_ready got=%b exp=0000", got_ready); end
            nvec++; if (o_valid !== 1'b1 || o_data !== 8'd15 || o_channel !== 2'd0) begin
                nerr++; $display("FAIL bp hold got v=%b d=%0d ch=%0d exp v=1 d=15 ch=0", o_valid, o_data, o_channel);
            end
        end
        src_valid = '0; src_ordy = 1'b1;
        for (int k = 0; k < CH; k++) begin
            step();
            nvec++; if (em_ch.size() != k + 1 || em_ch[k] != k || em_data[k] != S * (k + 1)) begin
                nerr++; $display("FAIL bp drain step %0d emitted=%0d exp ch=%0d d=%0d", k, em_ch.size(), k, S * (k + 1));
            end
        end
        repeat (2) step();
        nvec++; if (em_ch.size() != CH) begin nerr++; $display("FAIL bp total count got=%0d exp=%0d", em_ch.size(), CH); end
    endtask

    task automatic test_reset_mid_epoch();
        apply_reset();
        src_ordy = 1'b1; src_valid = 4'b0100; src_data[2] = 8'd5;
        for (int i = 0; i < 20 && acc[2] < 7; i++) step();
        src_valid = '0;
        @(negedge clk);
        i_valid = '0;
        #2 reset = 1'b0;
        #1;
        nvec++; if (o_valid !== 1'b0 || o_data !== 8'd0 || o_channel !== 2'd0 || i_ready !== 4'b0000) begin
            nerr++; $display("FAIL midrst during got v=%b d=%0d ch=%0d r=%b exp all 0", o_valid, o_data, o_channel, i_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        src_data[2] = 8'd1; src_valid = 4'b0100;
        for (int i = 0; i < 40 && acc[2] < S; i++) begin
            step();
            nvec++; if (o_valid !== m_ov || o_data !== m_od || o_channel !== m_och) begin
                nerr++; $display("FAIL midrst out got v=%b d=%0d ch=%0d exp v=%b d=%0d ch=%0d", o_valid, o_data, o_channel, m_ov, m_od, m_och);
            end
        end
        src_valid = '0;
        repeat (4) step();
        nvec++; if (em_ch.size() != 1 || em_ch[0] != 2 || em_data[0] != 15) begin
            nerr++; $display("FAIL midrst emitted %0d totals, first d=%0d exp one total ch2=15", em_ch.size(), (em_data.size() > 0) ? em_data[0] : -1);
        end
    endtask

    task automatic test_same_edge();
        int last1;
        apply_reset();
        src_ordy = 1'b0; src_valid = 4'b0100; src_data[2] = 8'd3;
        for (int i = 0; i < 40 && acc[2] < S; i++) step();
        src_valid = '0;
        repeat (2) step();
        src_data[0] = 8'd4; src_data[1] = 8'd1; src_data[3] = 8'd6;
        last1 = 6;
        for (int i = 0; i < 80 && !(acc[0] == S && acc[3] == S && i > 40); i++) begin
            src_valid = {acc[3] < S, 1'b0, i >= 6 && acc[1] < S - 1, acc[0] < S};
            step();
            if (got_ready[1]) last1 = i;
            nvec++; if (src_valid[1] && i - last1 > 2) begin nerr++; $display("FAIL same ch1 starved at %0d since %0d", i, last1); end
            nvec++; if (o_valid !== m_ov || o_data !== m_od || o_channel !== m_och) begin
                nerr++; $display("FAIL same out got v=%b d=%0d ch=%0d exp v=%b d=%0d ch=%0d", o_valid, o_data, o_channel, m_ov, m_od, m_och);
            end
        end
        src_valid = '0; src_ordy = 1'b1;
        repeat (6) step();
        nvec++; if (em_ch.size() != 3) begin nerr++; $display("FAIL same emit count got=%0d exp=3", em_ch.size()); end
        else begin
            nvec++; if (em_ch[0] != 2 || em_data[0] != 45) begin nerr++; $display("FAIL same first got ch=%0d d=%0d exp ch=2 d=45", em_ch[0], em_data[0]); end
            nvec++; if (em_ch[1] != 0 || em_data[1] != 60) begin nerr++; $display("FAIL same second got ch=%0d d=%0d exp ch=0 d=60", em_ch[1], em_data[1]); end
            nvec++; if (em_ch[2] != 3 || em_data[2] != 90) begin nerr++; $display("FAIL same third got ch=%0d d=%0d exp ch=3 d=90", em_ch[2], em_data[2]); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < CH; c++) begin
                if (!src_valid[c] || got_ready[c]) begin
                    src_valid[c] = ($urandom_range(2) != 0);
                    src_data[c]  = DW'($urandom);
                end
            end
            src_ordy = ((i % 120) < 35) ? 1'b0 : ($urandom_range(3) != 0);
            step();
            nvec++; if (got_ready !== exp_ready) begin nerr++; $display("FAIL random i_ready cycle %0d got=%b exp=%b", i, got_ready, exp_ready); end
            nvec++; if (o_valid !== m_ov || o_data !== m_od || o_channel !== m_och) begin
                nerr++; $display("FAIL random out cycle %0d got v=%b d=%0d ch=%0d exp v=%b d=%0d ch=%0d", i, o_valid, o_data, o_channel, m_ov, m_od, m_och);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_single_channel();
        test_round_robin();
        test_overflow();
        test_backpressure();
        test_reset_mid_epoch();
        test_same_edge();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
